memory_arbiter: RTL and testbench
=================================

# memory_arbiter

- Shares the single `memory_controller` port between two requesters: the instruction-fetch unit (IF) and the execute-stage data port (DP).
- Arbitrates round-robin and issues one-cycle read/write strobes on the `memory_pins` master side.
- Drives `read_type`, waits for `mem_finished`, then returns read data and a one-cycle `done` to the winning requester.
- A watchdog aborts stalled transactions so the CPU never hangs on a lost handshake.

## Interface
Parameters:
- TIMEOUT, 15: max cycles in WAIT before abort (4-bit counter, range 4..15)
- HOLDOFF, 3: cycles after reset release before first issue

Ports:
- clk  in  1  system clock, all logic posedge
- rst_n  in  1  synchronous reset, active low
- if_req  in  1  IF request, held until if_done
- if_addr  in  12  IF address (`word`)
- if_done  out  1  one-cycle completion pulse to IF
- if_err  out  1  qualifies if_done: timeout abort
- dp_req  in  1  DP request, held until dp_done
- dp_we  in  1  DP write (1) / read (0)
- dp_addr  in  12  DP address
- dp_wdata  in  12  DP write data
- dp_done  out  1  one-cycle completion pulse to DP
- dp_err  out  1  qualifies dp_done: timeout abort
- rdata  out  12  read data, valid only with if_done/dp_done
- read_type  out  1  `INSTRUCTION_FETCH` or `DATA_READ`; to controller
- pins  memory_pins.master  -  address, write_data, read_enable, write_enable (out); read_data, mem_finished (in)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If holdoff count is nonzero, decrement and stay.
  - Else, if either req is high, latch the winner's id, address, we and wdata, then go to ISSUE.
- ISSUE: drive read_enable (read) or write_enable (write) high for exactly one cycle; go to WAIT.
- WAIT:
  - On mem_finished=1: capture pins.read_data into rdata (writes capture 0); go to RESP.
  - When watchdog reaches TIMEOUT: rdata=0, set err; go to RESP.
- RESP: pulse done (and err, if set) of the latched requester; requests are ignored this cycle; go to IDLE.
- Arbitration:
  - Single request: it wins.
  - Both requesting: the requester not granted last wins.
  - last_grant updates on every grant.
- Outputs:
  - read_type = INSTRUCTION_FETCH for IF grants, DATA_READ for DP grants, including writes.
  - pins.address and write_data come from the latched registers and hold stable ISSUE through RESP.
  - IF never writes.
- mem_finished outside WAIT is ignored.

## Timing
- All outputs are registered.
- Reset values: enables 0, done/err 0, rdata 0, address 0, write_data 0, read_type DATA_READ, state IDLE, last_grant DP (IF wins the first tie), holdoff=HOLDOFF, watchdog 0.
- Nominal latency: req sampled at edge 0 → ISSUE cycle 1 → controller READ/WRITE cycle 2 → DONE (mem_finished) cycle 3 → done high cycle 4.
- Throughput: 5 cycles per access, back-to-back.
- Requester rules:
  - Keep req, addr, we and wdata stable until done.
  - Req still high in the cycle after done is treated as a new request.
- Watchdog:
  - Clears on entry to WAIT and increments each WAIT cycle.
  - Abort when count == TIMEOUT; done then arrives TIMEOUT+2 cycles after ISSUE.
  - mem_finished in the same cycle as the abort wins: normal completion, err=0.
- Reset mid-transaction: all state returns to reset values immediately; the pending requester gets no done.
- Post-reset holdoff: HOLDOFF cycles let an in-flight controller transaction drain to IDLE before the next strobe.
- Simultaneous reqs arriving while busy: both are evaluated only in IDLE.

## Structure
- Add to `memory_utils` package: `arb_state_t` enum (IDLE, ISSUE, WAIT, RESP) and `requester_t` enum (REQ_IF, REQ_DP).
- Reuse existing `word` type from `memory_utils`; reuse `DATA_READ`/`INSTRUCTION_FETCH` macros from `CPU_Definitions`.
- Sub-module `mem_rr_picker`: combinational 2-way round-robin selection plus the registered last_grant.
- FSM, latches and watchdog stay in `memory_arbiter`.

## Test plan
- IF read only, addr 0200 holding 7402: if_done at cycle 4 with rdata=7402, read_type=IF during ISSUE, dp_done never asserted.
- DP write 0300←1234, then DP read 0300: second dp_done returns rdata=1234; write_enable high exactly one cycle.
- Both reqs held continuously from reset: grants alternate IF, DP, IF, DP; each done 5 cycles apart.
- Stub controller never asserts mem_finished, DP read: dp_done with dp_err=1 and rdata=0 at TIMEOUT+2 cycles after ISSUE; next request serviced normally.
- rst_n low during WAIT, then released with if_req high: no done for the aborted op; first read_enable appears exactly HOLDOFF+1 cycles after release.
- Stray mem_finished pulse while IDLE: no done, no state change.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: 12-bit word, arbiter state,
// requester identity, controller read-type codes and the tie-break helper.
package memory_arbiter_pkg;

  localparam int WORD_W = 12;

  typedef logic [WORD_W-1:0] word;

  // read_type codes seen by the memory controller.
  localparam logic DATA_READ         = 1'b0;
  localparam logic INSTRUCTION_FETCH = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_DP
  } requester_t;

  // Two-way round-robin choice: a lone requester wins; on a tie the side
  // that was not granted last time wins.
  function automatic requester_t rr_pick(input logic       if_req,
                                         input logic       dp_req,
                                         input requester_t last_grant);
    if (if_req && dp_req) begin
      return (last_grant == REQ_IF) ? REQ_DP : REQ_IF;
    end
    if (if_req) begin
      return REQ_IF;
    end
    return REQ_DP;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Pin bundle between the arbiter (master) and the memory controller (slave).
interface memory_pins;
  import memory_arbiter_pkg::*;

  word  address;
  word  write_data;
  logic read_enable;
  logic write_enable;
  word  read_data;
  logic mem_finished;

  modport master (
    output address,
    output write_data,
    output read_enable,
    output write_enable,
    input  read_data,
    input  mem_finished
  );

  modport slave (
    input  address,
    input  write_data,
    input  read_enable,
    input  write_enable,
    output read_data,
    output mem_finished
  );

endinterface

// File: rtl/memory_arbiter_picker.sv
// Round-robin picker for the IF and DP requesters: combinational winner
// selection plus the registered record of who was granted last.
module mem_rr_picker
  import memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req,
  input  logic       dp_req,
  input  logic       grant_en,
  output logic       any_req,
  output requester_t winner
);

  requester_t last_grant;

  // Combinational winner for the current request pair.
  // NOTE: every output is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    any_req = if_req | dp_req;
    winner  = rr_pick(if_req, dp_req, last_grant);
  end

  // Remember the latest grant; after reset DP counts as last, so IF wins the first tie.
  // NOTE: registers are written with <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= REQ_DP;
    end else if (grant_en) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory-controller port between instruction fetch (IF) and the
// execute-stage data port (DP). A four-state FSM latches the round-robin
// winner, issues a one-cycle strobe, waits for mem_finished (bounded by a
// watchdog) and returns a one-cycle done/err with the read data.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15,  // WAIT cycles before abort, 4..15
  parameter int HOLDOFF = 3    // idle cycles after reset before the first strobe
)(
  input  logic       clk,
  input  logic       rst_n,

  input  logic       if_req,
  input  word        if_addr,
  output logic       if_done,
  output logic       if_err,

  input  logic       dp_req,
  input  logic       dp_we,
  input  word        dp_addr,
  input  word        dp_wdata,
  output logic       dp_done,
  output logic       dp_err,

  output word        rdata,
  output logic       read_type,

  memory_pins.master pins
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);
  localparam logic [3:0] HOLDOFF_CNT = 4'(HOLDOFF);

  arb_state_t state;
  requester_t cur_req;      // requester owning the transaction in flight
  logic       cur_we;       // transaction in flight is a write
  logic [3:0] holdoff_cnt;  // post-reset drain time for the controller
  logic [3:0] watchdog;     // cycles spent in WAIT

  logic       any_req;
  requester_t winner;
  logic       grant;

  // A grant happens only from IDLE once the post-reset holdoff has expired;
  // requests arriving while busy are simply not looked at until then.
  assign grant = (state == IDLE) && (holdoff_cnt == 4'd0) && any_req;

  mem_rr_picker u_picker (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .dp_req   (dp_req),
    .grant_en (grant),
    .any_req  (any_req),
    .winner   (winner)
  );

  // Arbiter FSM with every output registered; strobes and done pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the reset branch lists every register, latched address/data included, so a reset mid-transaction leaves nothing stale on the pins.
      state             <= IDLE;
      cur_req           <= REQ_DP;
      cur_we            <= 1'b0;
      holdoff_cnt       <= HOLDOFF_CNT;
      watchdog          <= 4'd0;
      pins.read_enable  <= 1'b0;
      pins.write_enable <= 1'b0;
      pins.address      <= '0;
      pins.write_data   <= '0;
      read_type         <= DATA_READ;
      rdata             <= '0;
      if_done           <= 1'b0;
      if_err            <= 1'b0;
      dp_done           <= 1'b0;
      dp_err            <= 1'b0;
    end else begin
      pins.read_enable  <= 1'b0;
      pins.write_enable <= 1'b0;
      if_done           <= 1'b0;
      if_err            <= 1'b0;
      dp_done           <= 1'b0;
      dp_err            <= 1'b0;

      unique case (state)
        IDLE: begin
          if (holdoff_cnt != 4'd0) begin
            holdoff_cnt <= holdoff_cnt - 4'd1;
          end else if (any_req) begin
            // Latch the winner and raise its strobe so it is high during ISSUE.
            cur_req <= winner;
            state   <= ISSUE;
            if (winner == REQ_IF) begin
              // Instruction fetch is always a read.
              cur_we           <= 1'b0;
              pins.address     <= if_addr;
              pins.write_data  <= '0;
              read_type        <= INSTRUCTION_FETCH;
              pins.read_enable <= 1'b1;
            end else begin
              cur_we            <= dp_we;
              pins.address      <= dp_addr;
              pins.write_data   <= dp_wdata;
              read_type         <= DATA_READ;
              pins.read_enable  <= ~dp_we;
              pins.write_enable <= dp_we;
            end
          end
        end

        ISSUE: begin
          watchdog <= 4'd0;
          state    <= WAIT;
        end

        WAIT: begin
          // mem_finished takes priority over an abort in the same cycle.
          if (pins.mem_finished) begin
            rdata <= cur_we ? '0 : pins.read_data;
            state <= RESP;
            if (cur_req == REQ_IF) begin
              if_done <= 1'b1;
            end else begin
              dp_done <= 1'b1;
            end
          end else if (watchdog == TIMEOUT_CNT) begin
            rdata <= '0;
            state <= RESP;
            if (cur_req == REQ_IF) begin
              if_done <= 1'b1;
              if_err  <= 1'b1;
            end else begin
              dp_done <= 1'b1;
              dp_err  <= 1'b1;
            end
          end else begin
            watchdog <= watchdog + 4'd1;
          end
        end

        RESP: begin
          // done is high during this cycle; requests are not sampled here.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and memory contents.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int HOLDOFF = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic if_req   = 1'b0;
  word  if_addr  = '0;
  logic if_done, if_err;
  logic dp_req   = 1'b0;
  logic dp_we    = 1'b0;
  word  dp_addr  = '0;
  word  dp_wdata = '0;
  logic dp_done, dp_err;
  word  rdata;
  logic read_type;

  memory_pins mif ();

  memory_arbiter #(.TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_err    (if_err),
    .dp_req    (dp_req),
    .dp_we     (dp_we),
    .dp_addr   (dp_addr),
    .dp_wdata  (dp_wdata),
    .dp_done   (dp_done),
    .dp_err    (dp_err),
    .rdata     (rdata),
    .read_type (read_type),
    .pins      (mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Power-up memory contents, shared by the controller stub and the model.
  function automatic word init_word(input word a);
    if (a == 12'o0200) return 12'o7402;
    return 12'(a * 12'd5 + 12'o0017);
  endfunction

  // ---------------- controller stub ----------------
  // Sees a strobe, then raises mem_finished stub_delay cycles later
  // (stub_delay = 1 gives the nominal timing, 0 never answers).
  word  stub_mem [4096];
  logic stub_seeded = 1'b0;
  int   stub_delay  = 1;
  int   stub_cnt    = 0;
  word  stub_hold   = '0;
  word  stub_rdata  = '0;
  logic stub_fin    = 1'b0;
  logic stray_fin   = 1'b0;

  assign mif.read_data    = stub_rdata;
  assign mif.mem_finished = stub_fin | stray_fin;

  always @(posedge clk) begin
    if (!stub_seeded) begin
      for (int a = 0; a < 4096; a++) stub_mem[a] <= init_word(12'(a));
      stub_seeded <= 1'b1;
    end
    stub_fin <= 1'b0;
    if (mif.read_enable || mif.write_enable) begin
      stub_hold <= stub_mem[mif.address];
      if (mif.write_enable) stub_mem[mif.address] <= mif.write_data;
      stub_cnt <= stub_delay;
    end else if (stub_cnt == 1) begin
      stub_fin   <= 1'b1;
      stub_rdata <= stub_hold;
      stub_cnt   <= 0;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  // Reference memory image kept by the bench.
  word ref_mem [4096];

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Runs one request from an idle arbiter and reports what was observed.
  // lat counts posedges from the request (1 = grant edge); -1 if no done.
  task automatic run_txn(input requester_t who, input logic we, input word addr,
                         input word wdata, input int budget,
                         output int lat, output word data, output logic err,
                         output int re_cnt, output int we_cnt,
                         output int other_done, output logic rt_issue);
    lat = -1; data = '0; err = 1'b0; re_cnt = 0; we_cnt = 0;
    other_done = 0; rt_issue = 1'b0;
    if (who == REQ_IF) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      dp_req = 1'b1; dp_we = we; dp_addr = addr; dp_wdata = wdata;
    end
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); @(negedge clk);
      re_cnt += int'(mif.read_enable);
      we_cnt += int'(mif.write_enable);
      if (k == 1) rt_issue = read_type;
      if ((who == REQ_IF) ? dp_done : if_done) other_done++;
      if ((who == REQ_IF) ? if_done : dp_done) begin
        lat  = k;
        data = rdata;
        err  = (who == REQ_IF) ? if_err : dp_err;
        break;
      end
    end
    if_req = 1'b0;
    dp_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; dp_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mif.read_enable, mif.write_enable} !== 2'b00) begin
      errors++; $display("FAIL reset_enables: got %b required 00", {mif.read_enable, mif.write_enable});
    end
    checks++;
    if ({if_done, if_err, dp_done, dp_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_done_err: got %b required 0000", {if_done, if_err, dp_done, dp_err});
    end
    checks++;
    if (rdata !== 12'o0) begin
      errors++; $display("FAIL reset_rdata: got %o required 0", rdata);
    end
    checks++;
    if (mif.address !== 12'o0 || mif.write_data !== 12'o0) begin
      errors++; $display("FAIL reset_addr_wdata: got %o/%o required 0/0", mif.address, mif.write_data);
    end
    checks++;
    if (read_type !== DATA_READ) begin
      errors++; $display("FAIL reset_read_type: got %b required %b", read_type, DATA_READ);
    end
    rst_n = 1'b1;
    idle(HOLDOFF + 2);
  endtask

  task automatic test_if_read();
    int lat, re_c, we_c, oth; word d; logic e, rt;
    idle(2);
    run_txn(REQ_IF, 1'b0, 12'o0200, '0, 20, lat, d, e, re_c, we_c, oth, rt);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL if_read_latency: got %0d required 4", lat); end
    checks++;
    if (d !== 12'o7402) begin errors++; $display("FAIL if_read_data: got %o required 7402", d); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL if_read_err: got %b required 0", e); end
    checks++;
    if (rt !== INSTRUCTION_FETCH) begin errors++; $display("FAIL if_read_type: got %b required %b", rt, INSTRUCTION_FETCH); end
    checks++;
    if (re_c !== 1 || we_c !== 0) begin errors++; $display("FAIL if_read_strobes: got re=%0d we=%0d required re=1 we=0", re_c, we_c); end
    checks++;
    if (oth !== 0) begin errors++; $display("FAIL if_read_dp_done: got %0d pulses required 0", oth); end
  endtask

  task automatic test_write_read();
    int lat, re_c, we_c, oth; word d; logic e, rt;
    idle(2);
    run_txn(REQ_DP, 1'b1, 12'o0300, 12'o1234, 20, lat, d, e, re_c, we_c, oth, rt);
    ref_mem[12'o0300] = 12'o1234;
    checks++;
    if (we_c !== 1 || re_c !== 0) begin errors++; $display("FAIL dp_write_strobes: got we=%0d re=%0d required we=1 re=0", we_c, re_c); end
    checks++;
    if (lat !== 4 || d !== 12'o0 || e !== 1'b0) begin
      errors++; $display("FAIL dp_write_done: got lat=%0d rdata=%o err=%b required lat=4 rdata=0 err=0", lat, d, e);
    end
    checks++;
    if (rt !== DATA_READ) begin errors++; $display("FAIL dp_write_type: got %b required %b", rt, DATA_READ); end
    idle(2);
    run_txn(REQ_DP, 1'b0, 12'o0300, '0, 20, lat, d, e, re_c, we_c, oth, rt);
    checks++;
    if (lat !== 4 || d !== 12'o1234 || e !== 1'b0) begin
      errors++; $display("FAIL dp_read_back: got lat=%0d rdata=%o err=%b required lat=4 rdata=1234 err=0", lat, d, e);
    end
  endtask

  task automatic test_alternate();
    int n_done = 0;
    int prev_k = 0;
    word a_if = 12'o0200;
    word a_dp = 12'o0300;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = a_if;
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = a_dp;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 60 && n_done < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (if_done || dp_done) begin
        requester_t exp_who = (n_done % 2 == 0) ? REQ_IF : REQ_DP;
        word exp_d = (exp_who == REQ_IF) ? ref_mem[a_if] : ref_mem[a_dp];
        int exp_k = (n_done == 0) ? HOLDOFF + 4 : prev_k + 5;
        checks++;
        if ({if_done, dp_done} !== ((exp_who == REQ_IF) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_order_%0d: got if/dp done=%b%b required %s", n_done, if_done, dp_done, (exp_who == REQ_IF) ? "IF" : "DP");
        end
        checks++;
        if (k !== exp_k) begin errors++; $display("FAIL alt_timing_%0d: got cycle %0d required %0d", n_done, k, exp_k); end
        checks++;
        if (rdata !== exp_d) begin errors++; $display("FAIL alt_data_%0d: got %o required %o", n_done, rdata, exp_d); end
        prev_k = k;
        n_done++;
      end
    end
    if_req = 1'b0; dp_req = 1'b0;
    checks++;
    if (n_done !== 6) begin errors++; $display("FAIL alt_count: got %0d dones required 6", n_done); end
  endtask

  task automatic test_timeout();
    int lat, re_c, we_c, oth; word d; logic e, rt;
    stub_delay = 0;
    idle(2);
    run_txn(REQ_DP, 1'b0, 12'o0005, '0, 40, lat, d, e, re_c, we_c, oth, rt);
    checks++;
    if (lat !== TIMEOUT + 3 || e !== 1'b1 || d !== 12'o0) begin
      errors++; $display("FAIL timeout_abort: got lat=%0d err=%b rdata=%o required lat=%0d err=1 rdata=0", lat, e, d, TIMEOUT + 3);
    end
    stub_delay = 1;
    idle(2);
    run_txn(REQ_DP, 1'b0, 12'o0005, '0, 20, lat, d, e, re_c, we_c, oth, rt);
    checks++;
    if (lat !== 4 || e !== 1'b0 || d !== ref_mem[12'o0005]) begin
      errors++; $display("FAIL timeout_recover: got lat=%0d err=%b rdata=%o required lat=4 err=0 rdata=%o", lat, e, d, ref_mem[12'o0005]);
    end
    // mem_finished lands in the very cycle the watchdog would abort.
    stub_delay = TIMEOUT;
    idle(2);
    run_txn(REQ_IF, 1'b0, 12'o0006, '0, 40, lat, d, e, re_c, we_c, oth, rt);
    checks++;
    if (lat !== TIMEOUT + 3 || e !== 1'b0 || d !== ref_mem[12'o0006]) begin
      errors++; $display("FAIL timeout_tie: got lat=%0d err=%b rdata=%o required lat=%0d err=0 rdata=%o", lat, e, d, TIMEOUT + 3, ref_mem[12'o0006]);
    end
    stub_delay = 1;
  endtask

  task automatic test_reset_mid();
    int stray_done = 0;
    int done_k = -1;
    word d = '0;
    stub_delay = 0;
    idle(2);
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 12'o0007;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0; dp_req = 1'b0;
    if_req = 1'b1; if_addr = 12'o0010;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (if_done || dp_done) stray_done++;
    end
    rst_n = 1'b1;
    stub_delay = 1;
    for (int k = 1; k <= HOLDOFF + 1; k++) begin
      @(posedge clk); @(negedge clk);
      if (if_done || dp_done) stray_done++;
      checks++;
      if (mif.read_enable !== (k == HOLDOFF + 1)) begin
        errors++; $display("FAIL rst_mid_holdoff_k%0d: got read_enable=%b required %b", k, mif.read_enable, (k == HOLDOFF + 1));
      end
    end
    for (int k = HOLDOFF + 2; k <= HOLDOFF + 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (dp_done) stray_done++;
      if (if_done) begin done_k = k; d = rdata; break; end
    end
    if_req = 1'b0;
    checks++;
    if (stray_done !== 0) begin errors++; $display("FAIL rst_mid_aborted_done: got %0d pulses required 0", stray_done); end
    checks++;
    if (done_k !== HOLDOFF + 4 || d !== ref_mem[12'o0010]) begin
      errors++; $display("FAIL rst_mid_next_if: got cycle=%0d rdata=%o required cycle=%0d rdata=%o", done_k, d, HOLDOFF + 4, ref_mem[12'o0010]);
    end
  endtask

  task automatic test_stray();
    int bad = 0;
    int lat, re_c, we_c, oth; word d; logic e, rt;
    idle(2);
    stray_fin = 1'b1;
    @(posedge clk); @(negedge clk);
    stray_fin = 1'b0;
    repeat (4) begin
      if (if_done || dp_done || mif.read_enable || mif.write_enable) bad++;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stray_finish: got %0d active cycles required 0", bad); end
    run_txn(REQ_IF, 1'b0, 12'o0200, '0, 20, lat, d, e, re_c, we_c, oth, rt);
    checks++;
    if (lat !== 4 || d !== 12'o7402) begin
      errors++; $display("FAIL stray_then_read: got lat=%0d rdata=%o required lat=4 rdata=7402", lat, d);
    end
  endtask

  // Randomized traffic: each requester holds until its done, then may
  // re-request at once. The model tracks when the arbiter is free (5 cycles
  // per access), resolves ties by "whoever was not granted last", and
  // predicts done timing (grant + 3) and data from its own memory image.
  task automatic test_random();
    requester_t m_last = REQ_DP;
    requester_t exp_who = REQ_IF;
    requester_t w;
    int   next_free = 1;
    int   cyc = 0;
    int   exp_cyc = 0;
    logic pend = 1'b0;
    word  exp_data = '0;
    logic exp_if, exp_dp;

    rst_n = 1'b0; if_req = 1'b0; dp_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(HOLDOFF + 2);

    for (int n = 0; n < 400; n++) begin
      @(posedge clk); cyc++; @(negedge clk);
      exp_if = pend && (exp_cyc == cyc) && (exp_who == REQ_IF);
      exp_dp = pend && (exp_cyc == cyc) && (exp_who == REQ_DP);
      checks++;
      if (if_done !== exp_if) begin errors++; $display("FAIL rand_if_done@%0d: got %b required %b", cyc, if_done, exp_if); end
      checks++;
      if (dp_done !== exp_dp) begin errors++; $display("FAIL rand_dp_done@%0d: got %b required %b", cyc, dp_done, exp_dp); end
      if (exp_if || exp_dp) begin
        checks++;
        if (rdata !== exp_data || if_err !== 1'b0 || dp_err !== 1'b0) begin
          errors++; $display("FAIL rand_data@%0d: got rdata=%o err=%b%b required rdata=%o err=00", cyc, rdata, if_err, dp_err, exp_data);
        end
        pend = 1'b0;
      end

      if (!if_req || exp_if) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 12'($urandom_range(0, 15));
      end
      if (!dp_req || exp_dp) begin
        dp_req   = ($urandom_range(0, 2) != 0);
        dp_we    = 1'($urandom_range(0, 1));
        dp_addr  = 12'($urandom_range(0, 15));
        dp_wdata = 12'($urandom);
      end

      if (!pend && (cyc + 1 >= next_free) && (if_req || dp_req)) begin
        if (if_req && dp_req) w = (m_last == REQ_IF) ? REQ_DP : REQ_IF;
        else                  w = if_req ? REQ_IF : REQ_DP;
        m_last    = w;
        exp_who   = w;
        pend      = 1'b1;
        exp_cyc   = cyc + 4;
        next_free = cyc + 6;
        if (w == REQ_DP && dp_we) begin
          exp_data         = '0;
          ref_mem[dp_addr] = dp_wdata;
        end else begin
          exp_data = ref_mem[(w == REQ_IF) ? if_addr : dp_addr];
        end
      end
    end
    if_req = 1'b0; dp_req = 1'b0;
    idle(8);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ref_mem[a] = init_word(12'(a));
    test_reset();
    test_if_read();
    test_write_read();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_stray();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
